// File: rtl/iob_eth_rx_frame.sv
// iob_eth_rx_frame
//   Ethernet frame receiver with a configurable PHY path (MII nibbles or GMII
//   bytes). It hunts for the SFD, assembles bytes, writes them to the frame
//   buffer, checks the FCS inline and holds a completed frame for the
//   consumer until it is acknowledged.
//
// Parameters
//   PHY_W       4 = MII (low nibble first), 8 = GMII
//   BUF_ADDR_W  byte address width of the frame buffer (2^BUF_ADDR_W bytes)
//
// Ports
//   clk, rst          RX clock, synchronous active-high reset
//   rx_dv, rx_data    PHY receive path (already synchronised to clk)
//   local_mac         station address, [47:40] is the first byte on the wire
//   wr, addr, data    buffer write port, one strobe per received byte
//   data_rcvd         a completed frame is held for the consumer
//   rcv_ack           consumer releases the frame
//   frame_len         byte count including FCS (saturating)
//   crc_err           FCS residue mismatch or odd nibble count
//   overflow          frame exceeded buffer capacity
//
// Build option
//   IOB_ETH_RX_MAC_FILTER_EN  drop frames whose destination is neither
//                             local_mac nor broadcast
module iob_eth_rx_frame #(
    parameter int PHY_W      = 4,
    parameter int BUF_ADDR_W = 11
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_dv,
    input  logic [PHY_W-1:0]      rx_data,
    input  logic [47:0]           local_mac,
    output logic                  wr,
    output logic [BUF_ADDR_W-1:0] addr,
    output logic [7:0]            data,
    output logic                  data_rcvd,
    input  logic                  rcv_ack,
    output logic [BUF_ADDR_W:0]   frame_len,
    output logic                  crc_err,
    output logic                  overflow
);

    localparam int          CNT_W    = BUF_ADDR_W + 1;
    localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_RES  = 32'hC704_DD7B;
    localparam logic [31:0] CRC_POLY = 32'h04C1_1DB7;

    typedef enum logic [2:0] {IDLE, DATA, CHECK, DONE, DRAIN} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] byte_cnt;
    logic [31:0]      crc;

    logic             sfd_hit;    // SFD seen on the current sample
    logic             byte_vld;   // a byte completes on the current sample
    logic [7:0]       byte_val;
    logic             half_byte;  // MII: a low nibble is pending
    logic             dst_reject; // destination filter says drop

    // CRC-32 with the register shifting MSB first and data fed in wire
    // order (bit 0 of each byte first); a good frame leaves CRC_RES behind.
    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++)
            r = {r[30:0], 1'b0} ^ (((r[31] ^ b[i]) != 1'b0) ? CRC_POLY : 32'h0);
        return r;
    endfunction

    // ------------------------------------------------------------------
    // PHY path: byte assembly and SFD detection
    // ------------------------------------------------------------------
    generate
        if (PHY_W == 4) begin : g_mii
            logic [3:0] prev_nib;
            logic [3:0] lo_nib;
            logic       nib_hi;

            always_ff @(posedge clk) begin
                if (rst) begin
                    prev_nib <= 4'h0;
                    lo_nib   <= 4'h0;
                    nib_hi   <= 1'b0;
                end else begin
                    // cleared while idle on the line so a stale nibble
                    // cannot pair with the next frame's first nibble
                    prev_nib <= rx_dv ? rx_data[3:0] : 4'h0;
                    // nib_hi survives into CHECK so an odd count is visible
                    if (state != DATA)
                        nib_hi <= 1'b0;
                    else if (rx_dv) begin
                        nib_hi <= ~nib_hi;
                        if (!nib_hi)
                            lo_nib <= rx_data[3:0];
                    end
                end
            end

            assign sfd_hit   = rx_dv && ({rx_data[3:0], prev_nib} == 8'hD5);
            assign byte_vld  = (state == DATA) && rx_dv && nib_hi;
            assign byte_val  = {rx_data[3:0], lo_nib};
            assign half_byte = nib_hi;
        end else begin : g_gmii
            assign sfd_hit   = rx_dv && (rx_data[7:0] == 8'hD5);
            assign byte_vld  = (state == DATA) && rx_dv;
            assign byte_val  = rx_data[7:0];
            assign half_byte = 1'b0;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Destination address filter
    // ------------------------------------------------------------------
`ifdef IOB_ETH_RX_MAC_FILTER_EN
    logic       uc_ok, bc_ok, uc_nxt, bc_nxt;
    logic [7:0] mac_byte;

    always_comb begin
        mac_byte = 8'h00;
        case (byte_cnt[2:0])
            3'd0:    mac_byte = local_mac[47:40];
            3'd1:    mac_byte = local_mac[39:32];
            3'd2:    mac_byte = local_mac[31:24];
            3'd3:    mac_byte = local_mac[23:16];
            3'd4:    mac_byte = local_mac[15:8];
            3'd5:    mac_byte = local_mac[7:0];
            default: mac_byte = 8'h00;
        endcase
    end

    assign uc_nxt     = uc_ok && (byte_val == mac_byte);
    assign bc_nxt     = bc_ok && (byte_val == 8'hFF);
    assign dst_reject = byte_vld && (byte_cnt == CNT_W'(5)) && !uc_nxt && !bc_nxt;

    always_ff @(posedge clk) begin
        if (rst || state != DATA) begin
            uc_ok <= 1'b1;
            bc_ok <= 1'b1;
        end else if (byte_vld && byte_cnt < CNT_W'(6)) begin
            uc_ok <= uc_nxt;
            bc_ok <= bc_nxt;
        end
    end
`else
    logic unused_mac;
    assign unused_mac = ^local_mac;
    assign dst_reject = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (sfd_hit) state_nxt = DATA;
            DATA:    if (!rx_dv) state_nxt = CHECK;
                     else if (dst_reject) state_nxt = DRAIN;
            CHECK:   state_nxt = (byte_cnt < CNT_W'(14)) ? IDLE : DONE;
            DONE:    if (rcv_ack) state_nxt = rx_dv ? DRAIN : IDLE;
            DRAIN:   if (!rx_dv) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath and status
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            wr        <= 1'b0;
            addr      <= '0;
            data      <= 8'h00;
            data_rcvd <= 1'b0;
            frame_len <= '0;
            crc_err   <= 1'b0;
            overflow  <= 1'b0;
            byte_cnt  <= '0;
            crc       <= CRC_INIT;
        end else begin
            wr <= 1'b0;
            case (state)
                IDLE: begin
                    if (state_nxt == DATA) begin
                        byte_cnt  <= '0;
                        crc       <= CRC_INIT;
                        frame_len <= '0;
                        crc_err   <= 1'b0;
                        overflow  <= 1'b0;
                    end
                end
                DATA: begin
                    if (byte_vld) begin
                        crc <= crc_byte(crc, byte_val);
                        // saturating count doubles as the frame_len clamp
                        if (byte_cnt != '1)
                            byte_cnt <= byte_cnt + CNT_W'(1);
                        if (byte_cnt[BUF_ADDR_W])
                            overflow <= 1'b1;
                        else begin
                            wr   <= 1'b1;
                            addr <= byte_cnt[BUF_ADDR_W-1:0];
                            data <= byte_val;
                        end
                    end
                end
                CHECK: begin
                    frame_len <= byte_cnt;
                    crc_err   <= (crc != CRC_RES) || half_byte;
                    if (state_nxt == DONE)
                        data_rcvd <= 1'b1;
                end
                DONE: begin
                    if (rcv_ack)
                        data_rcvd <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_iob_eth_rx_frame.sv
// Bench for iob_eth_rx_frame: three instances (MII 2 KiB buffer, MII 64-byte
// buffer, GMII 2 KiB buffer). Expected buffer writes and frame reports are
// queued as frames are driven and checked as the DUTs produce them.
module tb_iob_eth_rx_frame;

    localparam logic [47:0] MAC   = 48'h02_11_22_33_44_55;
    localparam logic [47:0] BCAST = 48'hFF_FF_FF_FF_FF_FF;
    localparam logic [47:0] OTHER = 48'h02_00_00_00_00_01;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       dv0 = 0, dv1 = 0, dv2 = 0;
    logic [3:0] rxd0 = 0, rxd1 = 0;
    logic [7:0] rxd2 = 0;
    logic       ack0 = 0, ack1 = 0, ack2 = 0;

    logic [2:0]  wr, rcvd, crce, ovf;
    logic [10:0] addr0, addr2;
    logic [5:0]  addr1;
    logic [7:0]  dat0, dat1, dat2;
    logic [11:0] flen0, flen2;
    logic [6:0]  flen1;

    iob_eth_rx_frame #(.PHY_W(4), .BUF_ADDR_W(11)) u_mii (
        .clk(clk), .rst(rst), .rx_dv(dv0), .rx_data(rxd0), .local_mac(MAC),
        .wr(wr[0]), .addr(addr0), .data(dat0), .data_rcvd(rcvd[0]), .rcv_ack(ack0),
        .frame_len(flen0), .crc_err(crce[0]), .overflow(ovf[0]));

    iob_eth_rx_frame #(.PHY_W(4), .BUF_ADDR_W(6)) u_ovf (
        .clk(clk), .rst(rst), .rx_dv(dv1), .rx_data(rxd1), .local_mac(MAC),
        .wr(wr[1]), .addr(addr1), .data(dat1), .data_rcvd(rcvd[1]), .rcv_ack(ack1),
        .frame_len(flen1), .crc_err(crce[1]), .overflow(ovf[1]));

    iob_eth_rx_frame #(.PHY_W(8), .BUF_ADDR_W(11)) u_gmii (
        .clk(clk), .rst(rst), .rx_dv(dv2), .rx_data(rxd2), .local_mac(MAC),
        .wr(wr[2]), .addr(addr2), .data(dat2), .data_rcvd(rcvd[2]), .rcv_ack(ack2),
        .frame_len(flen2), .crc_err(crce[2]), .overflow(ovf[2]));

    typedef struct { int sel; int addr; int data; } wr_t;
    typedef struct { int sel; int len; bit crc; bit ovf; } rep_t;

    wr_t  wr_q[$];
    rep_t rep_q[$];
    int   n_vec = 0, n_err = 0;
    int   cyc = 0, fall_cyc = 0;
    logic [7:0] frm [0:255];
    logic [2:0] rcvd_q = 3'b000;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // reference CRC: reflected software form
    function automatic logic [31:0] crc_ref(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'h0, b};
        for (int i = 0; i < 8; i++)
            r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
        return r;
    endfunction

    task automatic build(input logic [47:0] dst, input int n);
        logic [31:0] c;
        logic [47:0] src;
        src = 48'h02_AA_BB_CC_DD_EE;
        c = 32'hFFFF_FFFF;
        for (int i = 0; i < n - 4; i++) begin
            if (i < 6)        frm[i] = dst[47-8*i -: 8];
            else if (i < 12)  frm[i] = src[47-8*(i-6) -: 8];
            else if (i == 12) frm[i] = 8'h08;
            else if (i == 13) frm[i] = 8'h00;
            else              frm[i] = 8'($urandom);
            c = crc_ref(c, frm[i]);
        end
        c = ~c;
        for (int k = 0; k < 4; k++) frm[n-4+k] = c[8*k +: 8];
    endtask

    task automatic drive(input int sel, input logic v, input logic [7:0] d);
        case (sel)
            0:       begin dv0 = v; rxd0 = d[3:0]; end
            1:       begin dv1 = v; rxd1 = d[3:0]; end
            default: begin dv2 = v; rxd2 = d; end
        endcase
    endtask

    task automatic set_ack(input int sel, input logic v);
        case (sel)
            0:       ack0 = v;
            1:       ack1 = v;
            default: ack2 = v;
        endcase
    endtask

    task automatic put_byte(input int sel, input logic [7:0] b);
        if (sel == 2) begin
            @(posedge clk); #1 drive(sel, 1'b1, b);
        end else begin
            @(posedge clk); #1 drive(sel, 1'b1, {4'h0, b[3:0]});
            @(posedge clk); #1 drive(sel, 1'b1, {4'h0, b[7:4]});
        end
    endtask

    // n bytes of frm after preamble/SFD; writes expected for bytes < wlim;
    // abort_at pulses rst in place of that byte; half appends a lone nibble
    task automatic send(input int sel, input int n, input int wlim, input bit rep,
                        input bit bad, input int abort_at, input bit half);
        rep_t r;
        int   cap;
        cap = (sel == 1) ? 64 : 2048;
        for (int i = 0; i < 8; i++) put_byte(sel, (i == 7) ? 8'hD5 : 8'h55);
        for (int i = 0; i < n; i++) begin
            if (i == abort_at) begin
                @(posedge clk); #1 rst = 1'b1; drive(sel, 1'b0, 8'h00);
                @(posedge clk); #1 rst = 1'b0;
                return;
            end
            if (i < wlim) wr_q.push_back('{sel, i, int'(frm[i])});
            put_byte(sel, frm[i]);
        end
        if (half) begin
            @(posedge clk); #1 drive(sel, 1'b1, 8'h0A);
        end
        @(posedge clk); #1 drive(sel, 1'b0, 8'h00);
        fall_cyc = cyc;
        if (rep) begin
            r = '{sel, n, bad || half, n > cap};
            rep_q.push_back(r);
        end
    endtask

    task automatic ack_frame(input int sel);
        int t;
        t = 0;
        while (!rcvd[sel] && t < 200) begin @(negedge clk); t++; end
        chk("rcvd_seen", rcvd[sel], 1);
        @(posedge clk); #1 set_ack(sel, 1'b1);
        @(posedge clk); #1 set_ack(sel, 1'b0);
        @(negedge clk); chk("rcvd_clr", rcvd[sel], 0);
        repeat (4) @(posedge clk);
    endtask

    task automatic mon_wr(input int sel, input int a, input int d);
        wr_t e;
        if (wr_q.size() == 0) chk("wr_unexpected", wr_q.size(), 1);
        else begin
            e = wr_q.pop_front();
            chk("wr_sel", sel, e.sel);
            chk("wr_addr", a, e.addr);
            chk("wr_data", d, e.data);
        end
    endtask

    task automatic mon_rep(input int sel, input int len, input bit ce, input bit ov);
        rep_t e;
        if (rep_q.size() == 0) chk("rep_unexpected", rep_q.size(), 1);
        else begin
            e = rep_q.pop_front();
            chk("rep_sel", sel, e.sel);
            chk("rep_len", len, e.len);
            chk("rep_crc", ce, e.crc);
            chk("rep_ovf", ov, e.ovf);
            chk("rep_latency", cyc - fall_cyc, 2);
        end
    endtask

    always @(negedge clk) begin
        if (wr[0]) mon_wr(0, int'(addr0), int'(dat0));
        if (wr[1]) mon_wr(1, int'(addr1), int'(dat1));
        if (wr[2]) mon_wr(2, int'(addr2), int'(dat2));
        if (rcvd[0] && !rcvd_q[0]) mon_rep(0, int'(flen0), crce[0], ovf[0]);
        if (rcvd[1] && !rcvd_q[1]) mon_rep(1, int'(flen1), crce[1], ovf[1]);
        if (rcvd[2] && !rcvd_q[2]) mon_rep(2, int'(flen2), crce[2], ovf[2]);
        rcvd_q <= rcvd;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_wr", wr, 0);
        chk("rst_rcvd", rcvd, 0);
        chk("rst_crc_err", crce, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_addr", addr0, 0);
        chk("rst_data", dat0, 0);
        chk("rst_len0", flen0, 0);
        chk("rst_len2", flen2, 0);
        @(posedge clk); #1 rst = 1'b0;
        repeat (4) @(posedge clk);

        // good 64-byte MII frame to our address
        build(MAC, 64);
        send(0, 64, 64, 1, 0, -1, 0);
        ack_frame(0);

        // corrupted payload byte
        build(MAC, 64);
        frm[20] = frm[20] ^ 8'h10;
        send(0, 64, 64, 1, 1, -1, 0);
        ack_frame(0);

        // 100 bytes into a 64-byte buffer
        build(MAC, 100);
        send(1, 100, 64, 1, 0, -1, 0);
        ack_frame(1);

        // GMII broadcast, then a second frame arrives while the first is held
        build(BCAST, 60);
        send(2, 60, 60, 1, 0, -1, 0);
        t = 0;
        while (!rcvd[2] && t < 50) begin @(negedge clk); t++; end
        chk("gmii_rcvd", rcvd[2], 1);
        build(BCAST, 60);
        fork
            send(2, 60, 0, 0, 0, -1, 0);
            begin
                repeat (20) @(posedge clk);
                #1 ack2 = 1'b1;
                @(posedge clk); #1 ack2 = 1'b0;
                @(negedge clk);
                chk("gmii_rcvd_clr", rcvd[2], 0);
                chk("gmii_len_held", flen2, 60);
            end
        join
        repeat (10) @(posedge clk);
        build(MAC, 20);
        send(2, 20, 20, 1, 0, -1, 0);
        ack_frame(2);

        // foreign destination address
        build(OTHER, 64);
`ifdef IOB_ETH_RX_MAC_FILTER_EN
        send(0, 64, 6, 0, 0, -1, 0);
        repeat (20) @(posedge clk);
`else
        send(0, 64, 64, 1, 0, -1, 0);
        ack_frame(0);
`endif

        // reset in the middle of a frame
        build(MAC, 64);
        send(0, 64, 30, 0, 0, 30, 0);
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("abort_rcvd", rcvd[0], 0);
        chk("abort_len", flen0, 0);
        build(MAC, 64);
        send(0, 64, 64, 1, 0, -1, 0);
        ack_frame(0);

        // runt
        build(MAC, 10);
        send(0, 10, 10, 0, 0, -1, 0);
        repeat (20) @(posedge clk);

        // trailing lone nibble
        build(MAC, 20);
        send(0, 20, 20, 1, 0, -1, 1);
        ack_frame(0);

        repeat (10) @(posedge clk);
        chk("wr_q_empty", wr_q.size(), 0);
        chk("rep_q_empty", rep_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/iob_eth_rx_frame.md
# iob_eth_rx_frame

Parametrised Ethernet frame receiver that replaces the fixed 4-bit receiver with a configurable-width PHY path (MII or GMII). It hunts for the SFD, assembles bytes, and writes them to the frame buffer. It checks the FCS inline and reports frame length, CRC status and buffer overflow. It sits between the PHY RX pins (already synchronised to `clk`) and the RX buffer/CPU interface, and uses a data_rcvd/rcv_ack handshake to release each frame.

## Interface
Parameters:
- `PHY_W`, 4, PHY data width: 4 = MII (low nibble first), 8 = GMII. Other values are illegal.
- `BUF_ADDR_W`, 11, byte address width of the frame buffer; capacity is 2^BUF_ADDR_W bytes.

Ports:
- `clk` in 1: single clock, the RX clock domain.
- `rst` in 1: synchronous, active-high reset.
- `rx_dv` in 1: PHY data valid.
- `rx_data` in PHY_W: PHY receive data.
- `local_mac` in 48: station MAC address; the first byte on the wire is [47:40].
- `wr` out 1: buffer write strobe, one cycle per byte.
- `addr` out BUF_ADDR_W: buffer byte address.
- `data` out 8: buffer write data.
- `data_rcvd` out 1: a completed frame is held for the consumer.
- `rcv_ack` in 1: consumer releases the frame.
- `frame_len` out BUF_ADDR_W+1: received byte count, FCS included.
- `crc_err` out 1: FCS residue mismatch or alignment error.
- `overflow` out 1: the frame exceeded buffer capacity.

## Operation
- States: IDLE, DATA, CHECK, DONE, DRAIN.
- IDLE:
  - MII: keep the previous nibble; when `rx_dv`=1 and {rx_data, prev_nibble}==8'hD5, go to DATA. The SFD sets nibble phase; the next nibble is the low nibble of byte 0.
  - GMII: go to DATA when `rx_dv`=1 and rx_data==8'hD5.
- DATA:
  - Each completed byte: `data`=byte, `wr`=1 for one cycle, `addr`=byte index starting at 0. The CRC-32 (poly 04C11DB7, init FFFFFFFF) is updated with the byte. The byte counter increments.
  - Counter ≥ 2^BUF_ADDR_W: no `wr`, `overflow` sets, counting continues.
  - `rx_dv`=0 sampled: go to CHECK.
- CHECK (one cycle):
  - `frame_len` = byte count, saturating at 2^(BUF_ADDR_W+1)-1.
  - `crc_err` = (residue != 32'hC704DD7B) OR (MII and an odd nibble count).
  - Frames shorter than 14 bytes are runts: discarded, return to IDLE, no `data_rcvd`.
  - Otherwise go to DONE.
- DONE: `data_rcvd`=1. On `rcv_ack`=1, clear `data_rcvd`; go to IDLE if `rx_dv`=0, else DRAIN. Traffic during DONE is ignored.
- DRAIN: wait for `rx_dv`=0, then go to IDLE.
- `rcv_ack` outside DONE is ignored.

## Timing
- Reset values:
  - `wr`, `data_rcvd`, `crc_err`, `overflow` = 0.
  - `addr`, `data`, `frame_len` = 0.
  - State = IDLE; CRC = FFFFFFFF.
- Reset during any state aborts the frame on the next edge. No `data_rcvd` is produced.
- Write latency: `wr` is asserted the cycle after the `rx_data` sample that completes the byte (MII: the high nibble).
- `addr`/`data` are valid only while `wr`=1.
- `rx_dv` falling edge to `data_rcvd`=1 is 2 cycles: one to enter CHECK, one to enter DONE.
- `frame_len`, `crc_err` and `overflow` are stable from `data_rcvd` rise until the cycle after `rcv_ack`. They clear on entry to DATA.
- `data_rcvd` falls the cycle after `rcv_ack` is sampled high.
- `rx_dv`=1 while `rcv_ack` is asserted goes to DRAIN; the in-progress frame is lost by design.
- MII with `rx_dv` dropping after a low nibble only: the partial byte is not written and `crc_err`=1.

## Configuration
- `IOB_ETH_RX_MAC_FILTER_EN` defined:
  - After byte 5, compare the destination address with `local_mac` and with FF:FF:FF:FF:FF:FF.
  - On mismatch, go to DRAIN. No `data_rcvd` is produced; bytes already written are left stale.
- Undefined: every non-runt frame is delivered; `local_mac` is unused.

## Test plan
- MII, 64-byte frame with correct FCS, dest = `local_mac` -> 64 `wr` pulses at addr 0..63 with matching data, `data_rcvd`=1 2 cycles after `rx_dv` falls, `frame_len`=64, `crc_err`=0, `overflow`=0. `rcv_ack` -> `data_rcvd`=0 the next cycle.
- Same frame with byte 20 bit-flipped -> `frame_len`=64, `crc_err`=1.
- BUF_ADDR_W=6, 100-byte valid frame -> 64 writes (addr 0..63), `overflow`=1, `frame_len`=100, `crc_err`=0.
- PHY_W=8, 60-byte valid broadcast frame; second frame starts while `data_rcvd`=1 -> first reported `frame_len`=60. Second frame: no `wr`, not reported.
- Filter enabled, dest 02:00:00:00:00:01 ≠ `local_mac` -> `data_rcvd` stays 0 and the next valid frame is received normally. Filter disabled -> delivered.
- `rst` pulsed at byte 30 of a frame, then a fresh 64-byte frame -> no report for the aborted frame. Fresh frame gives `frame_len`=64, `crc_err`=0. A 10-byte runt -> no `data_rcvd`.
